menu_ctrl: RTL

//  Menu navigation controller: debounces four raw push-buttons and walks the

---
 rtl/menu_ctrl_pkg.sv | 47 ++++
 rtl/menu_ctrl_btn_debounce.sv | 50 +++++
 rtl/menu_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/menu_ctrl_pkg.sv
// Shared mode, song and phase codes for the menu controller, plus mode-step helpers.
package menu_ctrl_pkg;

  typedef enum logic [2:0] {
    ModeFree = 3'd0,
    ModeAuto = 3'd1,
    ModeStdy = 3'd2,
    ModePlay = 3'd3,
    ModeSet  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    PhBrowseMode = 2'd0,
    PhBrowseSong = 2'd1,
    PhRun        = 2'd2
  } phase_e;

  localparam logic [2:0] SongLittleStar = 3'd0;

  // Illegal codes fall back to the free mode.
  function automatic logic [2:0] mode_next(input logic [2:0] m);
    case (m)
      ModeFree: return ModeAuto;
      ModeAuto: return ModeStdy;
      ModeStdy: return ModePlay;
      ModePlay: return ModeSet;
      ModeSet:  return ModeFree;
      default:  return ModeFree;
    endcase
  endfunction

  function automatic logic [2:0] mode_prev(input logic [2:0] m);
    case (m)
      ModeFree: return ModeSet;
      ModeAuto: return ModeFree;
      ModeStdy: return ModeAuto;
      ModePlay: return ModeStdy;
      ModeSet:  return ModePlay;
      default:  return ModeFree;
    endcase
  endfunction

  function automatic logic mode_has_song(input logic [2:0] m);
    return (m == ModeAuto) || (m == ModeStdy) || (m == ModePlay);
  endfunction

endpackage

// File: rtl/menu_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, level debouncer and one-cycle press detector.
module menu_ctrl_btn_debounce #(
  parameter int unsigned DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            level_dly_q;
  logic            armed_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  // Synchroniser resets high so a button held through reset never arms the
  // press detector until a release has actually been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], btn};
      armed_q     <= armed_q | ~sync_q[1];
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q & armed_q;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CntW'(DB_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/menu_ctrl.sv
// Menu navigation controller: debounced buttons drive the mode/song menu and
// produce start/stop strobes on entry to and exit from the run phase.
module menu_ctrl
  import menu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 2_000_000,
  parameter int unsigned NUM_SONGS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       song_done,
  output logic [2:0] state,
  output logic [2:0] song,
  output logic [1:0] phase,
  output logic       active,
  output logic       start_pulse,
  output logic       stop_pulse
);

  localparam logic [2:0] SongLast = 3'(NUM_SONGS - 1);

  logic [3:0] raw;
  logic [3:0] press;
  logic [2:0] state_q;
  logic [2:0] song_q;
  phase_e     phase_q;
  logic       start_q;
  logic       stop_q;

  assign raw = {btn_back, btn_ok, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    menu_ctrl_btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .press(press[i])
    );
  end

  // The if/else chains encode event priority: back > ok > up > down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ModeFree;
      song_q  <= SongLittleStar;
      phase_q <= PhBrowseMode;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (phase_q)
        PhBrowseMode: begin
          if (press[3]) begin
            phase_q <= PhBrowseMode;
          end else if (press[2]) begin
            if (state_q == ModeFree || state_q == ModeSet) begin
              phase_q <= PhRun;
              start_q <= 1'b1;
            end else if (mode_has_song(state_q)) begin
              phase_q <= PhBrowseSong;
            end else begin
              state_q <= ModeFree;
            end
          end else if (press[0]) begin
            state_q <= mode_next(state_q);
          end else if (press[1]) begin
            state_q <= mode_prev(state_q);
          end
        end
        PhBrowseSong: begin
          if (press[3]) begin
            phase_q <= PhBrowseMode;
          end else if (press[2]) begin
            phase_q <= PhRun;
            start_q <= 1'b1;
          end else if (press[0]) begin
            song_q <= (song_q >= SongLast) ? 3'd0 : song_q + 3'd1;
          end else if (press[1]) begin
            song_q <= (song_q == 3'd0) ? SongLast : song_q - 3'd1;
          end
        end
        PhRun: begin
          if (press[3]) begin
            phase_q <= PhBrowseMode;
            stop_q  <= 1'b1;
          end else if (song_done && mode_has_song(state_q)) begin
            phase_q <= PhBrowseSong;
            stop_q  <= 1'b1;
          end
        end
        default: phase_q <= PhBrowseMode;
      endcase
    end
  end

  assign state       = state_q;
  assign song        = song_q;
  assign phase       = phase_q;
  assign active      = (phase_q == PhRun);
  assign start_pulse = start_q;
  assign stop_pulse  = stop_q;

endmodule
